// File: rtl/orb_pkg.sv
// Shared types and constants for the orbital telemetry frame reader.
package orb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } orb_state_e;

    localparam int ORB_WORD_W    = 12;
    localparam int ORB_ADDR_W    = 11;
    localparam int ORB_FRAME_LEN = 2048;

endpackage

// File: rtl/orb_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with any-edge detection.
module orb_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_edge  = r_sync ^ r_prev;

endmodule

// File: rtl/orb_frame_reader.sv
// Reads telemetry words from RAM and serialises them MSB-first with word/frame strobes.
// Optional build macro ORB_PARITY_EN appends an odd-parity bit to every word.
module orb_frame_reader
    import orb_pkg::*;
#(
    parameter int FRAME_LEN = ORB_FRAME_LEN,
    parameter int WORD_W    = ORB_WORD_W,
    parameter int BIT_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iEn,
    input  logic                  SW,
    input  logic [WORD_W-1:0]     RdData,
    output logic                  RdEn,
    output logic [ORB_ADDR_W-1:0] RdAddr,
    output logic                  oBit,
    output logic                  oWordStrb,
    output logic                  oFrameSync,
    output logic                  oRestart,
    output logic                  oBusy
);

`ifdef ORB_PARITY_EN
    localparam int NBITS = WORD_W + 1;
`else
    localparam int NBITS = WORD_W;
`endif
    localparam int DIV_W = $clog2(BIT_DIV);
    localparam int IDX_W = $clog2(NBITS);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NBITS - 1);
    localparam logic [ORB_ADDR_W-1:0] ADDR_LAST = ORB_ADDR_W'(FRAME_LEN - 1);

    function automatic logic [NBITS-1:0] form_word(input logic [WORD_W-1:0] d);
`ifdef ORB_PARITY_EN
        return {d, ~^d};
`else
        return d;
`endif
    endfunction

    orb_state_e             r_state, w_state_nxt;
    logic                   w_en, w_en_edge_unused, w_sw_level_unused, w_sw_edge;
    logic                   w_bit_end, w_word_end, w_prefetch, w_start, w_strb_now;
    logic [ORB_ADDR_W-1:0]  w_next_addr, r_addr;
    logic [DIV_W-1:0]       r_div;
    logic [IDX_W-1:0]       r_idx;
    logic [NBITS-1:0]       r_shreg, r_hold;
    logic                   r_rden, r_rd_pend, r_more, r_next_fs, r_cur_fs, r_rst_pend;
    logic                   r_obit, r_wstrb, r_fsync, r_restart, r_busy;

    orb_sync_edge u_sync_en (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_async (iEn),
        .o_level (w_en),
        .o_edge  (w_en_edge_unused)
    );

    orb_sync_edge u_sync_sw (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_async (SW),
        .o_level (w_sw_level_unused),
        .o_edge  (w_sw_edge)
    );

    // Prefetch sits on the first clk of the last bit so RdData lands in r_hold before the boundary.
    always_comb begin
        w_bit_end   = (r_state == SHIFT) && (r_div == DIV_LAST);
        w_word_end  = w_bit_end && (r_idx == IDX_LAST);
        w_prefetch  = (r_state == SHIFT) && (r_div == '0) && (r_idx == IDX_LAST) && w_en;
        w_start     = (r_state == IDLE) && w_en;
        w_strb_now  = (r_state == SHIFT) && (r_div == '0) && (r_idx == '0);
        w_next_addr = r_addr + 1'b1;
        if (r_rst_pend || w_sw_edge || (r_addr == ADDR_LAST)) begin
            w_next_addr = '0;
        end
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_en) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT:   if (w_word_end && !r_more) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rden     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_addr     <= '0;
            r_div      <= '0;
            r_idx      <= '0;
            r_more     <= 1'b0;
            r_next_fs  <= 1'b0;
            r_cur_fs   <= 1'b0;
            r_rst_pend <= 1'b0;
            r_obit     <= 1'b0;
            r_wstrb    <= 1'b0;
            r_fsync    <= 1'b0;
            r_restart  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rden    <= 1'b0;
            r_rd_pend <= r_rden;
            r_restart <= w_sw_edge;
            if (w_sw_edge) r_rst_pend <= 1'b1;
            if (r_rd_pend) r_hold <= form_word(RdData);
            if (w_start) begin
                r_rden     <= 1'b1;
                r_addr     <= '0;
                r_rst_pend <= 1'b0;
            end
            if (w_prefetch) begin
                r_rden     <= 1'b1;
                r_addr     <= w_next_addr;
                r_more     <= 1'b1;
                r_next_fs  <= (w_next_addr == '0);
                r_rst_pend <= 1'b0;
            end
            if (r_state == LOAD) begin
                r_shreg  <= form_word(RdData);
                r_div    <= '0;
                r_idx    <= '0;
                r_cur_fs <= 1'b1;
            end else if (r_state == SHIFT) begin
                if (w_word_end) begin
                    r_shreg  <= r_hold;
                    r_div    <= '0;
                    r_idx    <= '0;
                    r_more   <= 1'b0;
                    r_cur_fs <= r_next_fs;
                end else if (w_bit_end) begin
                    r_shreg <= r_shreg << 1;
                    r_div   <= '0;
                    r_idx   <= r_idx + 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            // Output stage: serial outputs lag the shift core by one clk.
            r_obit  <= (r_state == SHIFT) & r_shreg[NBITS-1];
            r_wstrb <= w_strb_now;
            r_fsync <= w_strb_now & r_cur_fs;
            r_busy  <= (r_state != IDLE) || (w_state_nxt != IDLE);
        end
    end

    assign RdEn       = r_rden;
    assign RdAddr     = r_addr;
    assign oBit       = r_obit;
    assign oWordStrb  = r_wstrb;
    assign oFrameSync = r_fsync;
    assign oRestart   = r_restart;
    assign oBusy      = r_busy;

endmodule

// File: tb/tb_orb_frame_reader.sv
// Directed bench for orb_frame_reader: 4-word frame, 4 clks per bit.
`timescale 1ns/1ps
module tb_orb_frame_reader;

    localparam int BD = 4;
`ifdef ORB_PARITY_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iEn = 1'b0;
    logic        SW  = 1'b0;
    logic [11:0] RdData = '0;
    logic        RdEn;
    logic [10:0] RdAddr;
    logic        oBit, oWordStrb, oFrameSync, oRestart, oBusy;
    logic [11:0] mem [4];
    int          errors = 0;
    int          checks = 0;

    orb_frame_reader #(.FRAME_LEN(4), .WORD_W(12), .BIT_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .iEn        (iEn),
        .SW         (SW),
        .RdData     (RdData),
        .RdEn       (RdEn),
        .RdAddr     (RdAddr),
        .oBit       (oBit),
        .oWordStrb  (oWordStrb),
        .oFrameSync (oFrameSync),
        .oRestart   (oRestart),
        .oBusy      (oBusy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data valid the cycle after RdEn.
    always @(posedge clk) if (RdEn) RdData <= mem[RdAddr[1:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] expw(input logic [11:0] w);
`ifdef ORB_PARITY_EN
        return {w, ~^w};
`else
        return w;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " RdEn"}, RdEn, 0);
        chk({tag, " RdAddr"}, RdAddr, 0);
        chk({tag, " oBit"}, oBit, 0);
        chk({tag, " oWordStrb"}, oWordStrb, 0);
        chk({tag, " oFrameSync"}, oFrameSync, 0);
        chk({tag, " oRestart"}, oRestart, 0);
        chk({tag, " oBusy"}, oBusy, 0);
    endtask

    // Called just after iEn goes high; ends one clk before word 0's strobe.
    task automatic start_seq(input string tag);
        tick(); chk({tag, " rden e1"}, RdEn, 0);
        tick(); chk({tag, " rden e2"}, RdEn, 0);
        tick(); chk({tag, " rden e3"}, RdEn, 1);
        chk({tag, " addr0"}, RdAddr, 0);
        chk({tag, " busy"}, oBusy, 1);
        tick(); chk({tag, " rden pulse"}, RdEn, 0);
        chk({tag, " strb e4"}, oWordStrb, 0);
        tick(); chk({tag, " strb e5"}, oWordStrb, 0);
    endtask

    task automatic run_word(input string tag, input logic [11:0] w, input logic fs,
                            input logic pf, input logic [10:0] pf_addr,
                            input int sw_at, input int stop_at);
        logic [NB-1:0] e;
        int rd_seen;
        int rs_seen;
        e = expw(w);
        rd_seen = 0;
        rs_seen = 0;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < BD; j++) begin
                tick();
                if (i == sw_at && j == 0) SW = ~SW;
                if (i == stop_at && j == 0) iEn = 1'b0;
                chk({tag, " bit"}, oBit, e[NB-1-i]);
                if (j == 0) begin
                    chk({tag, " strb"}, oWordStrb, (i == 0));
                    chk({tag, " fsync"}, oFrameSync, (i == 0) && fs);
                end
                if (RdEn) begin
                    rd_seen++;
                    chk({tag, " pf addr"}, RdAddr, pf_addr);
                    chk({tag, " pf time"}, (i == NB-1) && (j == 0), 1);
                end
                if (oRestart) rs_seen++;
            end
        end
        chk({tag, " rd count"}, rd_seen, pf);
        chk({tag, " restart count"}, rs_seen, (sw_at >= 0));
    endtask

    initial begin
        int k;
        int rs;
        mem[0] = 12'hA5C;
        mem[1] = 12'h3C1;
        mem[2] = 12'h0F0;
`ifdef ORB_PARITY_EN
        mem[3] = 12'h001;
`else
        mem[3] = 12'h5AA;
`endif
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick(); tick();
        chk("idle busy", oBusy, 0);

        iEn = 1'b1;
        start_seq("start");
        run_word("w0", mem[0], 1, 1, 11'd1, -1, -1);
        run_word("w1", mem[1], 0, 1, 11'd2, -1, -1);
        run_word("w2", mem[2], 0, 1, 11'd3, -1, -1);
        run_word("w3", mem[3], 0, 1, 11'd0, -1, -1);
        run_word("w4", mem[0], 1, 1, 11'd1, -1, -1);
        run_word("w5 sw", mem[1], 0, 1, 11'd0, 2, -1);
        run_word("w6 stop", mem[0], 1, 0, 11'd0, -1, 3);
        tick();
        chk("stop busy", oBusy, 0);
        chk("stop bit", oBit, 0);
        chk("stop strb", oWordStrb, 0);

        SW = 1'b0;
        rs = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (oRestart) rs++;
            if (RdEn) chk("idle no read", RdEn, 0);
        end
        chk("idle restart", rs, 1);
        chk("idle busy2", oBusy, 0);

        iEn = 1'b1;
        k = 0;
        while (!oWordStrb && k < 20) begin
            tick();
            k++;
        end
        chk("restart strobe seen", oWordStrb, 1);
        chk("restart fsync", oFrameSync, 1);
        tick();
        chk("pre-reset bit", oBit, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async reset");
        tick();
        rst = 1'b1;
        start_seq("after reset");
        run_word("r0", mem[0], 1, 1, 11'd1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
